tiny_cpu_sequencer: RTL and testbench

Program sequencer for the 4-bit accumulator datapath. It holds a small instruction memory that is loaded over a byte handshake. It runs a fetch/execute state machine that drives the ALU opcode, immediate and accumulator write-enable into the datapath, and resolves jumps from the datapath zero flag. It also supports free-run and single-step execution, HALT, and an output strobe for the tile pins.

---
 rtl/tiny_cpu_sequencer_if.sv | 23 ++
 rtl/tiny_cpu_sequencer.sv | 173 +++++++++++++++++
 tb/tb_tiny_cpu_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tiny_cpu_sequencer_if.sv
// Host/datapath bus of the tiny CPU sequencer: program-load handshake plus ALU control.
// The sequencer takes the slave side; the host and datapath take the master side.
interface tiny_cpu_sequencer_if;
   logic       load_valid;
   logic [7:0] load_data;
   logic       load_ready;
   logic       load_clear;
   logic [3:0] dp_acc;
   logic       dp_acc_zero;
   logic [3:0] dp_op;
   logic [3:0] dp_imm;
   logic       dp_acc_we;

   modport master (
      output load_valid, load_data, load_clear, dp_acc, dp_acc_zero,
      input  load_ready, dp_op, dp_imm, dp_acc_we
   );

   modport slave (
      input  load_valid, load_data, load_clear, dp_acc, dp_acc_zero,
      output load_ready, dp_op, dp_imm, dp_acc_we
   );
endinterface

// File: rtl/tiny_cpu_sequencer.sv
// Program sequencer for the 4-bit accumulator datapath: byte-loaded instruction memory,
// fetch/execute FSM with jumps, single-step, HALT and an OUT strobe.
module tiny_cpu_sequencer #(
   parameter int ADDR_W    = 4,
   parameter bit AUTO_WRAP = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   tiny_cpu_sequencer_if.slave  bus,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 step_mode,
   input  logic                 step,
   output logic                 out_valid,
   output logic [3:0]           out_data,
   output logic [ADDR_W-1:0]    pc,
   output logic                 busy,
   output logic                 halted
);

   localparam int                DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   LEN_MAX = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_PAUSE = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_LDI  = 4'h1,
      OP_ADD  = 4'h2,
      OP_SUB  = 4'h3,
      OP_AND  = 4'h4,
      OP_OR   = 4'h5,
      OP_XOR  = 4'h6,
      OP_JMP  = 4'h7,
      OP_JZ   = 4'h8,
      OP_OUT  = 4'h9,
      OP_HALT = 4'hF
   } opcode_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_d;
   logic [ADDR_W-1:0]   wptr;
   logic [ADDR_W:0]     prog_len;
   logic [7:0]          ir;
   logic [7:0]          mem [DEPTH];

   logic                load_fire;
   logic                last_instr;
   logic                seq_halt;
   logic [ADDR_W-1:0]   pc_seq;
   logic [ADDR_W-1:0]   jmp_target;
   logic [3:0]          ir_op;
   state_t              exec_next;
   logic                acc_we;
   logic                out_fire;

   assign bus.load_ready = (state_q == S_IDLE) || (state_q == S_HALT);
   assign load_fire      = bus.load_valid && bus.load_ready;

   assign ir_op      = ir[7:4];
   assign jmp_target = ADDR_W'(ir[3:0]);
   assign exec_next  = step_mode ? S_PAUSE : S_FETCH;

   // With prog_len == 0 the subtraction wraps to all ones, which no pc can match.
   assign last_instr = ({1'b0, pc} == (prog_len - LEN_ONE));
   assign seq_halt   = last_instr && !AUTO_WRAP;
   assign pc_seq     = (last_instr && AUTO_WRAP) ? '0 : pc + PC_ONE;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
      state_d  = state_q;
      pc_d     = pc;
      acc_we   = 1'b0;
      out_fire = 1'b0;

      case (state_q)
         S_IDLE, S_HALT: begin
            if (start && !abort && !load_fire && (prog_len != '0)) begin
               state_d = S_FETCH;
               pc_d    = '0;
            end
         end
         S_FETCH: state_d = S_EXEC;
         S_EXEC: begin
            state_d = exec_next;
            pc_d    = pc_seq;
            if (seq_halt) begin
               state_d = S_HALT;
               pc_d    = pc;
            end
            case (ir_op)
               OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: acc_we = 1'b1;
               OP_JMP: begin
                  state_d = exec_next;
                  pc_d    = jmp_target;
               end
               OP_JZ: begin
                  if (bus.dp_acc_zero) begin
                     state_d = exec_next;
                     pc_d    = jmp_target;
                  end
               end
               OP_OUT:  out_fire = 1'b1;
               OP_HALT: begin
                  state_d = S_HALT;
                  pc_d    = pc;
               end
               default: ;
            endcase
         end
         S_PAUSE: begin
            if (step) state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort overrides everything decided above, including a pending accumulator write.
      if (abort && (state_q != S_IDLE)) begin
         state_d  = S_IDLE;
         pc_d     = '0;
         acc_we   = 1'b0;
         out_fire = 1'b0;
      end
   end

   assign bus.dp_op     = (state_q == S_EXEC) ? ir[7:4] : 4'h0;
   assign bus.dp_imm    = (state_q == S_EXEC) ? ir[3:0] : 4'h0;
   assign bus.dp_acc_we = acc_we;

   assign busy   = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_PAUSE);
   assign halted = (state_q == S_HALT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pc        <= '0;
         ir        <= 8'h00;
         out_valid <= 1'b0;
         out_data  <= 4'h0;
      end else begin
         state_q   <= state_d;
         pc        <= pc_d;
         out_valid <= out_fire;
         if (state_q == S_FETCH) ir <= mem[pc];
         if (out_fire) out_data <= bus.dp_acc;
      end
   end

   // NOTE: the program store is a small flop array, so it is reset to NOP like any other state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr     <= '0;
         prog_len <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      end else if (bus.load_clear) begin
         wptr     <= '0;
         prog_len <= '0;
      end else if (load_fire) begin
         mem[wptr] <= bus.load_data;
         wptr      <= wptr + PC_ONE;
         if (prog_len != LEN_MAX) prog_len <= prog_len + LEN_ONE;
      end
   end

endmodule

// File: tb/tb_tiny_cpu_sequencer.sv
// Bench for tiny_cpu_sequencer: one wrapping and one halting instance, a datapath model
// on each, and an instruction-level reference model that predicts every cycle.
module tb_tiny_cpu_sequencer;

   logic       clk;
   logic       rst;
   logic       start, abort, step_mode, step;
   logic       load_valid, load_clear;
   logic [7:0] load_data;
   logic       sel;

   logic       ov_w, ov_h, busy_w, busy_h, halted_w, halted_h;
   logic [3:0] od_w, od_h, pc_w, pc_h, acc_w, acc_h;

   logic       o_we, o_ov, o_busy, o_halted, o_ready;
   logic [3:0] o_pc, o_op, o_imm, o_od, o_acc;

   logic [7:0] mem_m [16];
   logic [3:0] wp_m;
   int         len_m;
   int         n_cmp = 0;
   int         n_bad = 0;

   tiny_cpu_sequencer_if bus_w ();
   tiny_cpu_sequencer_if bus_h ();

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus_w.load_valid  = load_valid;
   assign bus_w.load_data   = load_data;
   assign bus_w.load_clear  = load_clear;
   assign bus_w.dp_acc      = acc_w;
   assign bus_w.dp_acc_zero = (acc_w == 4'd0);
   assign bus_h.load_valid  = load_valid;
   assign bus_h.load_data   = load_data;
   assign bus_h.load_clear  = load_clear;
   assign bus_h.dp_acc      = acc_h;
   assign bus_h.dp_acc_zero = (acc_h == 4'd0);

   tiny_cpu_sequencer #(.ADDR_W(4), .AUTO_WRAP(1'b1)) dut_wrap (
      .clk(clk), .rst(rst), .bus(bus_w), .start(start), .abort(abort),
      .step_mode(step_mode), .step(step), .out_valid(ov_w), .out_data(od_w),
      .pc(pc_w), .busy(busy_w), .halted(halted_w)
   );

   tiny_cpu_sequencer #(.ADDR_W(4), .AUTO_WRAP(1'b0)) dut_halt (
      .clk(clk), .rst(rst), .bus(bus_h), .start(start), .abort(abort),
      .step_mode(step_mode), .step(step), .out_valid(ov_h), .out_data(od_h),
      .pc(pc_h), .busy(busy_h), .halted(halted_h)
   );

   function automatic logic [3:0] alu(input logic [3:0] op, input logic [3:0] imm, input logic [3:0] acc);
      case (op)
         4'h1:    return imm;
         4'h2:    return acc + imm;
         4'h3:    return acc - imm;
         4'h4:    return acc & imm;
         4'h5:    return acc | imm;
         4'h6:    return acc ^ imm;
         default: return acc;
      endcase
   endfunction

   // Accumulator datapath attached to each sequencer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) acc_w <= 4'd0;
      else if (bus_w.dp_acc_we) acc_w <= alu(bus_w.dp_op, bus_w.dp_imm, acc_w);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) acc_h <= 4'd0;
      else if (bus_h.dp_acc_we) acc_h <= alu(bus_h.dp_op, bus_h.dp_imm, acc_h);
   end

   always_comb begin
      if (sel) begin
         o_we = bus_h.dp_acc_we; o_op = bus_h.dp_op; o_imm = bus_h.dp_imm; o_ready = bus_h.load_ready;
         o_ov = ov_h; o_od = od_h; o_pc = pc_h; o_busy = busy_h; o_halted = halted_h; o_acc = acc_h;
      end else begin
         o_we = bus_w.dp_acc_we; o_op = bus_w.dp_op; o_imm = bus_w.dp_imm; o_ready = bus_w.load_ready;
         o_ov = ov_w; o_od = od_w; o_pc = pc_w; o_busy = busy_w; o_halted = halted_w; o_acc = acc_w;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
      wp_m  = 4'd0;
      len_m = 0;
   endtask

   task automatic load_byte(input logic [7:0] b);
      load_valid = 1'b1;
      load_data  = b;
      check("load_ready", o_ready, 1);
      tick();
      load_valid = 1'b0;
      mem_m[wp_m] = b;
      wp_m = wp_m + 4'd1;
      if (len_m < 16) len_m++;
   endtask

   task automatic clear_prog();
      load_clear = 1'b1;
      tick();
      load_clear = 1'b0;
      wp_m  = 4'd0;
      len_m = 0;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic abort_pulse();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", o_busy, 0);
      check("abort_halted", o_halted, 0);
      check("abort_pc", o_pc, 0);
      check("abort_ready", o_ready, 1);
   endtask

   // Instruction-level model: 2 cycles per instruction, 'pauses' idle cycles plus a step pulse between instructions.
   task automatic run_check(input int max_instr, input int pauses, output bit done);
      logic [7:0] ins;
      logic [3:0] op, imm, m_pc, m_acc, exp_od;
      bit         exp_ov, zero;
      m_pc   = 4'd0;
      m_acc  = o_acc;
      exp_od = 4'd0;
      exp_ov = 1'b0;
      done   = 1'b0;
      for (int i = 0; i < max_instr && !done; i++) begin
         check("fetch_pc", o_pc, m_pc);
         check("fetch_busy", o_busy, 1);
         check("fetch_we", o_we, 0);
         check("fetch_out_valid", o_ov, exp_ov);
         if (exp_ov) check("fetch_out_data", o_od, exp_od);
         tick();
         ins = mem_m[m_pc];
         op  = ins[7:4];
         imm = ins[3:0];
         check("exec_pc", o_pc, m_pc);
         check("exec_op", o_op, op);
         check("exec_imm", o_imm, imm);
         check("exec_we", o_we, (op >= 4'h1 && op <= 4'h6));
         zero   = (m_acc == 4'd0);
         exp_ov = (op == 4'h9);
         if (exp_ov) exp_od = m_acc;
         m_acc = alu(op, imm, m_acc);
         if (op == 4'hF) done = 1'b1;
         else if (op == 4'h7 || (op == 4'h8 && zero)) m_pc = imm;
         else if (int'(m_pc) == len_m - 1) begin
            if (sel) done = 1'b1;
            else m_pc = 4'd0;
         end else m_pc = m_pc + 4'd1;
         tick();
         if (!done && pauses > 0) begin
            for (int k = 0; k < pauses; k++) begin
               check("pause_pc", o_pc, m_pc);
               check("pause_busy", o_busy, 1);
               check("pause_we", o_we, 0);
               check("pause_op", o_op, 0);
               check("pause_out_valid", o_ov, exp_ov);
               exp_ov = 1'b0;
               tick();
            end
            step = 1'b1;
            tick();
            step = 1'b0;
         end
      end
      if (done) begin
         check("halt_flag", o_halted, 1);
         check("halt_busy", o_busy, 0);
         check("halt_pc", o_pc, m_pc);
         check("halt_ready", o_ready, 1);
         check("halt_out_valid", o_ov, exp_ov);
         if (exp_ov) check("halt_out_data", o_od, exp_od);
      end
   endtask

   initial begin
      bit         done;
      int         len;
      int         pauses;
      logic [7:0] b;

      rst = 1'b1; start = 1'b0; abort = 1'b0; step_mode = 1'b0; step = 1'b0;
      load_valid = 1'b0; load_clear = 1'b0; load_data = 8'h00; sel = 1'b0;
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         check("rst_pc", o_pc, 0);
         check("rst_busy", o_busy, 0);
         check("rst_halted", o_halted, 0);
         check("rst_we", o_we, 0);
         check("rst_op", o_op, 0);
         check("rst_out_valid", o_ov, 0);
         check("rst_out_data", o_od, 0);
         check("rst_ready", o_ready, 1);
      end
      sel = 1'b0;
      rst = 1'b0;
      tick();

      // Start with an empty program is ignored.
      start_pulse();
      check("empty_start_busy", o_busy, 0);

      // LDI 3, ADD 2, OUT, HALT.
      load_byte(8'h13); load_byte(8'h22); load_byte(8'h90); load_byte(8'hF0);
      start_pulse();
      run_check(8, 0, done);
      abort_pulse();

      // JZ loop, wrapping instance.
      clear_prog();
      load_byte(8'h10); load_byte(8'h81); load_byte(8'h22); load_byte(8'h70);
      start_pulse();
      run_check(12, 0, done);
      abort_pulse();

      // Three NOPs: halting instance stops at pc 2, wrapping instance returns to 0.
      clear_prog();
      for (int i = 0; i < 3; i++) load_byte(8'h00);
      sel = 1'b1;
      start_pulse();
      run_check(6, 0, done);
      abort_pulse();
      sel = 1'b0;
      start_pulse();
      run_check(5, 0, done);
      abort_pulse();

      // Single-step with 10 idle cycles between instructions.
      clear_prog();
      load_byte(8'h13); load_byte(8'h22); load_byte(8'h90); load_byte(8'hF0);
      step_mode = 1'b1;
      start_pulse();
      run_check(6, 10, done);
      step_mode = 1'b0;
      abort_pulse();

      // Abort during EXEC of ADD suppresses the write.
      start_pulse();
      tick(); tick(); tick();
      check("abort_exec_op", o_op, 2);
      abort = 1'b1;
      #1;
      check("abort_exec_we", o_we, 0);
      tick();
      abort = 1'b0;
      check("abort_exec_busy", o_busy, 0);
      check("abort_exec_pc", o_pc, 0);
      check("abort_exec_acc", o_acc, 3);

      // Random programs on a random instance, sometimes single-stepped.
      for (int r = 0; r < 8; r++) begin
         clear_prog();
         len = $urandom_range(1, 16);
         for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            load_byte(b);
         end
         sel       = 1'($urandom_range(0, 1));
         step_mode = 1'($urandom_range(0, 1));
         pauses    = step_mode ? $urandom_range(1, 3) : 0;
         start_pulse();
         run_check(24, pauses, done);
         step_mode = 1'b0;
         abort_pulse();
      end
      sel = 1'b0;

      // Load handshake beats a same-cycle start.
      clear_prog();
      load_valid = 1'b1; load_data = 8'h13; start = 1'b1;
      tick();
      load_valid = 1'b0; start = 1'b0;
      mem_m[wp_m] = 8'h13; wp_m = wp_m + 4'd1; len_m++;
      check("load_start_busy", o_busy, 0);
      tick();
      check("load_start_busy2", o_busy, 0);

      // 17 loads: the last overwrites mem[0], length saturates at 16.
      clear_prog();
      for (int i = 0; i < 16; i++) load_byte(8'h10 | 8'(i));
      load_byte(8'h9A);
      sel = 1'b1;
      start_pulse();
      run_check(20, 0, done);
      abort_pulse();
      sel = 1'b0;

      // Reset mid-run, then memory must read back as NOP beyond a one-byte program.
      start_pulse();
      tick(); tick();
      rst = 1'b1;
      #1;
      check("midrst_pc", o_pc, 0);
      check("midrst_busy", o_busy, 0);
      check("midrst_halted", o_halted, 0);
      check("midrst_we", o_we, 0);
      check("midrst_op", o_op, 0);
      check("midrst_imm", o_imm, 0);
      check("midrst_out_valid", o_ov, 0);
      check("midrst_out_data", o_od, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_model();
      tick();
      load_byte(8'h75);
      start_pulse();
      run_check(14, 0, done);
      abort_pulse();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
